// File: rtl/muldiv_wb_arbiter_pkg.sv
// Shared types for the mul/div writeback arbiter.
package muldiv_wb_arbiter_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic {
        WB_SRC_MUL = 1'b0,
        WB_SRC_DIV = 1'b1
    } wb_src_e;
endpackage

// File: rtl/muldiv_wb_fifo.sv
// Small power-of-two FIFO holding multiplier results that could not be written back at once.
module muldiv_wb_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]               cnt_q;
    logic                         do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/muldiv_wb_arbiter.sv
// Merges pipelined-multiplier and serial-divider results onto one registered writeback port.
// Optional MULDIV_WB_PERF_EN adds saturating divider/writeback stall counters.
module muldiv_wb_arbiter
    import muldiv_wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned ID_W           = TRANS_ID_BITS,
    parameter int unsigned MUL_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             mul_vld_i,
    input  logic [ID_W-1:0]  mul_id_i,
    input  logic [WIDTH-1:0] mul_res_i,
    output logic             mul_rdy_o,
    input  logic             div_vld_i,
    output logic             div_rdy_o,
    input  logic [ID_W-1:0]  div_id_i,
    input  logic [WIDTH-1:0] div_res_i,
    output logic             wb_vld_o,
    input  logic             wb_rdy_i,
    output logic [ID_W-1:0]  wb_id_o,
    output logic [WIDTH-1:0] wb_res_o,
    output logic             wb_src_o,
    output logic             ovf_o
`ifdef MULDIV_WB_PERF_EN
    ,
    output logic [31:0]      div_stall_cnt_o,
    output logic [31:0]      wb_stall_cnt_o
`endif
);
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] res;
    } muldiv_wb_entry_t;

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    muldiv_wb_entry_t      mul_in, div_in, fifo_head, out_q;
    wb_src_e               src_q;
    logic                  wb_vld_q, ovf_q;
    logic [STARVE_W-1:0]   starve_q;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                  out_free, mul_in_vld, mul_cand, div_prio;
    logic                  div_gnt, mul_gnt, bypass, overflow;

    assign mul_in = '{id: mul_id_i, res: mul_res_i};
    assign div_in = '{id: div_id_i, res: div_res_i};

    always_comb begin
        out_free   = ~wb_vld_q | wb_rdy_i;
        mul_in_vld = mul_vld_i & ~flush_i;
        mul_cand   = ~fifo_empty | mul_in_vld;
        div_prio   = (starve_q == STARVE_W'(STARVE_LIMIT));
        div_gnt    = ~flush_i & out_free & div_vld_i & (~mul_cand | div_prio);
        mul_gnt    = ~flush_i & out_free & mul_cand & ~div_gnt;
        // An incoming mul skips the queue only when nothing older is waiting.
        bypass     = mul_gnt & fifo_empty;
        fifo_push  = mul_in_vld & ~bypass;
        fifo_pop   = mul_gnt & ~fifo_empty;
        overflow   = fifo_push & fifo_full & ~fifo_pop;
    end

    muldiv_wb_fifo #(
        .DEPTH  (MUL_FIFO_DEPTH),
        .DATA_W ($bits(muldiv_wb_entry_t))
    ) u_mul_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (mul_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_vld_q <= 1'b0;
            out_q    <= '0;
            src_q    <= WB_SRC_MUL;
        end else if (flush_i) begin
            wb_vld_q <= 1'b0;
        end else if (out_free) begin
            wb_vld_q <= div_gnt | mul_gnt;
            if (div_gnt) begin
                out_q <= div_in;
                src_q <= WB_SRC_DIV;
            end else if (mul_gnt) begin
                out_q <= fifo_empty ? mul_in : fifo_head;
                src_q <= WB_SRC_MUL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            starve_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (div_vld_i && !div_gnt) begin
                if (!div_prio)
                    starve_q <= starve_q + STARVE_W'(1);
            end else begin
                starve_q <= '0;
            end
            if (overflow)
                ovf_q <= 1'b1;
        end
    end

`ifdef MULDIV_WB_PERF_EN
    logic [31:0] div_stall_q, wb_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_stall_q <= '0;
            wb_stall_q  <= '0;
        end else begin
            if (div_vld_i && !div_gnt && div_stall_q != '1)
                div_stall_q <= div_stall_q + 32'd1;
            if (wb_vld_q && !wb_rdy_i && wb_stall_q != '1)
                wb_stall_q <= wb_stall_q + 32'd1;
        end
    end

    assign div_stall_cnt_o = div_stall_q;
    assign wb_stall_cnt_o  = wb_stall_q;
`endif

    assign mul_rdy_o = ~fifo_full;
    assign div_rdy_o = div_gnt;
    assign wb_vld_o  = wb_vld_q;
    assign wb_id_o   = out_q.id;
    assign wb_res_o  = out_q.res;
    assign wb_src_o  = src_q;
    assign ovf_o     = ovf_q;
endmodule
